// File: rtl/ex_mul_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul_seq_pkg
// Brief    : ALU opcode, sequencer state encoding and sizing helper for the
//            EX-stage multiply sequencer.
// Revision : 1.0
// ============================================================================
package ex_mul_seq_pkg;

  // This encoding is shared with ALU control; keep the two in sync.
  localparam logic [3:0] ALUOP_MUL_S = 4'b1011;

  typedef enum logic [1:0] {
    MULSEQ_IDLE = 2'd0,
    MULSEQ_BUSY = 2'd1,
    MULSEQ_DONE = 2'd2
  } mulseq_state_e;

  // Iteration counter width; a single-iteration loop still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : ex_mul_seq_pkg
`default_nettype wire

// File: rtl/ex_mul_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : mul_step
// Brief    : One shift-add iteration: acc + mcand * mplier slice, mod 2^WIDTH.
// Revision : 1.0
// ============================================================================
module mul_step
  import ex_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [BITS-1:0]  mplier_i,
  output logic [WIDTH-1:0] acc_o
);

  generate
    if (BITS == 1) begin : g_radix2
      assign acc_o = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    end else begin : g_radix_wide
      logic [WIDTH-1:0] pp;
      // Only the low WIDTH bits of the partial product can reach the result.
      assign pp    = mcand_i * WIDTH'(mplier_i);
      assign acc_o = acc_i + pp;
    end
  endgenerate

endmodule : mul_step
`default_nettype wire

// File: rtl/ex_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : ex_mul_seq
// Brief    : Multi-cycle radix-2^BITS shift-add multiplier for the EX stage.
//            Optional MUL_EARLY_TERM_EN ends the loop once the multiplier is 0.
// Revision : 1.0
// ============================================================================
module ex_mul_seq
  import ex_mul_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BITS  = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ex_valid_i,
  input  logic [3:0]       aluop_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  input  logic             ex_hold_i,
  output logic             mul_stall_o,
  output logic [WIDTH-1:0] mul_res_o,
  output logic             mul_res_valid_o,
  output logic             mul_busy_o
);

  localparam int unsigned      N        = WIDTH / BITS;
  localparam int unsigned      CNT_W    = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mulseq_state_e    state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] mcand_shift;
  logic [WIDTH-1:0] mplier_shift;
  logic             start;
  logic             last_iter;

  assign start = ex_valid_i && (aluop_i == ALUOP_MUL_S) && !flush_i
                 && (state_q == MULSEQ_IDLE);

  assign mcand_shift  = mcand_q << BITS;
  assign mplier_shift = mplier_q >> BITS;

  mul_step #(
    .WIDTH (WIDTH),
    .BITS  (BITS)
  ) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q[BITS-1:0]),
    .acc_o    (step_acc)
  );

`ifdef MUL_EARLY_TERM_EN
  // Nothing left to add once the shifted multiplier is empty.
  assign last_iter = (mplier_shift == '0) || (cnt_q == CNT_LAST);
`else
  assign last_iter = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d         = state_q;
    acc_d           = acc_q;
    mcand_d         = mcand_q;
    mplier_d        = mplier_q;
    cnt_d           = cnt_q;
    mul_stall_o     = 1'b0;
    mul_res_valid_o = 1'b0;

    if (flush_i) begin
      state_d = MULSEQ_IDLE;
    end else begin
      case (state_q)
        MULSEQ_IDLE: begin
          if (start) begin
            state_d     = MULSEQ_BUSY;
            acc_d       = '0;
            mcand_d     = op_a_i;
            mplier_d    = op_b_i;
            cnt_d       = '0;
            mul_stall_o = 1'b1;
          end
        end
        MULSEQ_BUSY: begin
          acc_d       = step_acc;
          mcand_d     = mcand_shift;
          mplier_d    = mplier_shift;
          cnt_d       = cnt_q + CNT_ONE;
          mul_stall_o = 1'b1;
          if (last_iter) begin
            state_d = MULSEQ_DONE;
          end
        end
        MULSEQ_DONE: begin
          // The MUL is still sitting in ID/EX here, so no relaunch is possible.
          mul_res_valid_o = 1'b1;
          if (!ex_hold_i) begin
            state_d = MULSEQ_IDLE;
          end
        end
        default: begin
          state_d = MULSEQ_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MULSEQ_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign mul_res_o  = acc_q;
  assign mul_busy_o = (state_q != MULSEQ_IDLE);

endmodule : ex_mul_seq
`default_nettype wire

// File: doc/ex_mul_seq.md
# ex_mul_seq

Multi-cycle multiply sequencer for the EX stage. It takes over any instruction whose decoded ALU operation is `ALUOP_MUL_S` and computes the low WIDTH bits of the product with a radix-2^BITS shift-add loop. While the loop runs it stalls IF/ID/EX, then hands the result to the EX/MEM register. The combinational ALU keeps all single-cycle operations; the EX result mux selects this block's result when `mul_res_valid` is high.

## Interface
- `WIDTH`, 32: operand and result width.
- `BITS`, 1: multiplier bits consumed per iteration.
  - Must divide WIDTH.
  - N = WIDTH/BITS is the iteration count.
- `clk` input 1: the single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ex_valid` input 1: the EX stage holds a live instruction.
- `aluop` input 4: ALU operation from ALU control.
- `op_a` input WIDTH: multiplicand (rs value after forwarding).
- `op_b` input WIDTH: multiplier (rt value after forwarding).
- `flush` input 1: kill the EX-stage instruction (branch/jump redirect).
- `ex_hold` input 1: downstream stall; EX/MEM cannot accept this cycle.
- `mul_stall` output 1: hold PC, IF/ID and ID/EX.
- `mul_res` output WIDTH: product, low WIDTH bits.
- `mul_res_valid` output 1: `mul_res` is final and selected into EX/MEM.
- `mul_busy` output 1: the state machine is not IDLE (debug/perf counter).

## Operation
- start = `ex_valid` & (`aluop`==`ALUOP_MUL_S`) & !`flush` & state==IDLE.
- States: IDLE, BUSY, DONE.
- **IDLE:**
  - On start: load acc=0, mcand=`op_a`, mplier=`op_b`, cnt=0, then go to BUSY.
  - Without start: stay in IDLE.
- **BUSY:** each cycle:
  - acc += mcand × mplier[BITS-1:0], truncated to WIDTH.
  - mcand <<= BITS; mplier >>= BITS; cnt++.
  - When cnt reaches N-1, go to DONE.
- **DONE:**
  - `mul_res`=acc and `mul_res_valid`=1.
  - If `ex_hold`, stay in DONE and keep acc stable.
  - Otherwise return to IDLE.
  - start is never evaluated in DONE. The MUL is still in ID/EX, so this prevents a re-launch.
- Arithmetic:
  - Low WIDTH bits of a two's-complement product equal the low bits of the unsigned product of the raw patterns, so no sign correction is applied.
  - All adds wrap mod 2^WIDTH.
- `flush` in any state: go to IDLE next edge; `mul_stall`=0 and `mul_res_valid`=0 in that same cycle (combinational).
- `rst_n` low at any time, including mid-operation: immediately IDLE, acc/mcand/mplier/cnt=0.
- Reset values: `mul_stall`=0, `mul_res`=0, `mul_res_valid`=0, `mul_busy`=0.
- Other aluop values: the block stays IDLE and all outputs are inactive.

## Timing
- `mul_stall` = (start) | (state==BUSY), combinational from registered state.
- `mul_stall` is low in DONE; `ex_hold` governs the pipeline there.
- For a start in cycle T:
  - BUSY occupies T+1..T+N.
  - DONE occurs at T+N+1, with `mul_res_valid`=1.
  - `mul_stall` is high for T..T+N (N+1 cycles).
- The MUL occupies EX for N+2 cycles, or more if `ex_hold` is asserted.
- Back-to-back MULs: the second starts in the cycle after the first leaves DONE. There is no bubble beyond DONE.
- `mul_res` is registered (acc); it is stable from DONE until the next start.

## Configuration
- `MUL_EARLY_TERM_EN`, when defined:
  - In BUSY, if the post-shift mplier is all-zero, go to DONE on the next edge regardless of cnt.
  - Latency becomes ceil(msb_index(op_b)+1 / BITS) BUSY cycles, minimum 1.
  - For op_b=0, exactly 1 BUSY cycle.
- When undefined: always N BUSY cycles, giving fixed latency. Results are identical either way.

## Structure
- `defs.v` holds the following:
  - `ALUOP_MUL_S`, which is already shared with ALU control.
  - New state encodings `MULSEQ_IDLE`, `MULSEQ_BUSY` and `MULSEQ_DONE` (2 bits).
- Sub-module `mul_step`: combinational; (acc, mcand, mplier slice) → next acc. It isolates the adder so BITS>1 can use a wider partial product.
- The FSM, counter (clog2(N) bits) and operand registers live in `ex_mul_seq`.

## Test plan
- Basic unsigned: op_a=3, op_b=5, `MUL_EARLY_TERM_EN` off, WIDTH=32, BITS=1.
  - `mul_stall` high exactly 33 cycles.
  - `mul_res_valid` pulses 1 cycle with `mul_res`=15.
- Signed and overflow cases:
  - -7×6 → 0xFFFFFFD6.
  - 0x80000000×0xFFFFFFFF → 0x80000000.
  - 0x10000×0x10000 → 0.
- Flush at cycle T+10:
  - `mul_stall` drops the same cycle.
  - `mul_busy` is 0 next cycle.
  - `mul_res_valid` never rises.
  - A following MUL (2×2) yields 4.
- `ex_hold` held 4 cycles in DONE: FSM stays in DONE, `mul_res` stays constant, `mul_stall`=0, and the FSM exits to IDLE one edge after `ex_hold` falls.
- Reset mid-operation: `rst_n` pulsed low at T+5, asynchronously, between clock edges.
  - All outputs go to 0 without a clock edge.
  - A fresh MUL 9×9 = 81 completes normally.
- `MUL_EARLY_TERM_EN` defined:
  - op_b=5 → 3 BUSY cycles, `mul_stall` 4 cycles, result 15.
  - op_b=0 → 1 BUSY cycle, result 0.
  - Back-to-back MULs start with no extra bubble.
